// File: rtl/ptos_tx.sv
//----------------------------------------------------------------------
// ptos_tx : transmit parallel-to-serial stage, MSB-first, COMMA sync/idle
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ptos_tx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       ready_out,
    output logic       active_out
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic       dout_q, dout_d;
    logic       load;
    logic [7:0] next_char;

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SYNC;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd7;
            sync_cnt_q <= 4'd0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            dout_q     <= dout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = {shift_q[6:0], 1'b0};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        sync_cnt_d = sync_cnt_q;
        dout_d     = shift_q[6];
        load       = (bit_cnt_q == 3'd7);
        next_char  = COMMA;

        // Offered data is only honoured once alignment has been sent.
        if ((state_q == ST_ACTIVE) && valid_in) begin
            next_char = data_in;
        end

        if (load) begin
            shift_d = next_char;
            dout_d  = next_char[7];
            if (state_q == ST_SYNC) begin
                sync_cnt_d = sync_cnt_q + 4'd1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end
        end
    end

    assign data_out   = dout_q;
    assign ready_out  = (state_q == ST_ACTIVE) && (bit_cnt_q == 3'd7);
    assign active_out = (state_q == ST_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_ptos_tx.sv
//----------------------------------------------------------------------
// tb_ptos_tx : directed self-checking bench for ptos_tx (SYNC_COUNT 4 and 1)
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ptos_tx;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       dout0, rdy0, act0;
    logic       dout1, rdy1, act1;

    int n_total = 0;
    int n_bad   = 0;

    // Load-edge table: entry k applies to load edge 8k+1 after reset release.
    logic       vin  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] din  [9] = '{8'hFF, 8'h96, 8'h00, 8'hBC, 8'hA5, 8'h3C, 8'h5A, 8'h00, 8'h3C};
    logic [7:0] exp0 [9] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'h5A, 8'hBC, 8'h3C};
    logic [7:0] exp1 [9] = '{8'hBC, 8'h96, 8'hBC, 8'hBC, 8'hA5, 8'h3C, 8'h5A, 8'hBC, 8'h3C};

    always #5 clk_8f = ~clk_8f;

    ptos_tx #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (dout0),
        .ready_out (rdy0),
        .active_out(act0)
    );

    ptos_tx #(.COMMA(8'hBC), .SYNC_COUNT(1)) dut1 (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (dout1),
        .ready_out (rdy1),
        .active_out(act1)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string where);
        chk({where, " dout0"}, dout0, 1'b0);
        chk({where, " rdy0"},  rdy0,  1'b0);
        chk({where, " act0"},  act0,  1'b0);
        chk({where, " dout1"}, dout1, 1'b0);
        chk({where, " rdy1"},  rdy1,  1'b0);
        chk({where, " act1"},  act1,  1'b0);
    endtask

    task automatic chk_edge(input int e, input logic [7:0] c0, input logic [7:0] c1);
        int pos;
        pos = (e - 1) % 8;
        chk($sformatf("dout0 e%0d", e), dout0, c0[7 - pos]);
        chk($sformatf("rdy0 e%0d", e),  rdy0,  (e >= 25) && (e % 8 == 0));
        chk($sformatf("act0 e%0d", e),  act0,  e >= 25);
        chk($sformatf("dout1 e%0d", e), dout1, c1[7 - pos]);
        chk($sformatf("rdy1 e%0d", e),  rdy1,  e % 8 == 0);
        chk($sformatf("act1 e%0d", e),  act1,  1'b1);
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        repeat (4) begin
            @(negedge clk_8f);
            chk_zero("in_reset");
        end

        reset = 1'b1;
        for (int e = 1; e <= 68; e++) begin
            @(negedge clk_8f);
            chk_edge(e, exp0[(e - 1) / 8], exp1[(e - 1) / 8]);
            if (e % 8 == 0) begin
                valid_in = vin[e / 8];
                data_in  = din[e / 8];
            end else begin
                // Junk on non-load edges must never reach the line.
                valid_in = (e % 2 == 1);
                data_in  = (e % 2 == 1) ? 8'hFF : 8'h00;
            end
        end

        // Mid-character reset: 3C is at bit_cnt 3 and data_out is high here.
        #2 reset = 1'b0;
        #1 chk_zero("async_reset");
        valid_in = 1'b1;
        data_in  = 8'hFF;
        repeat (2) begin
            @(negedge clk_8f);
            chk_zero("held_reset");
        end

        reset = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk_8f);
            chk_edge(e, (e <= 32) ? 8'hBC : 8'hFF, (e <= 8) ? 8'hBC : 8'hFF);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
